fx68k_prefetch_queue: RTL

- Parametrised instruction prefetch queue. Successor to the fixed IRC/IR word pair feeding the IRD decode path.
- Autonomously fetches program words ahead of decode into a DEPTH-word FIFO.
- Exposes the head word plus one lookahead word to the decoder.
- Discards all contents and any in-flight fetch on a PC flush (branch, exception, RTE).
- Sits between the micro-sequencer/decoder and the bus controller's program-space read channel.

---
 rtl/fx68k_pkg.sv | 19 +
 rtl/fx68k_pfq_ram.sv | 70 +++++++
 rtl/fx68k_prefetch_queue.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fx68k_pkg.sv
// Shared types for the fx68k prefetch queue: FSM state encoding, queue entry layout
// and the upper bound on queue depth.
package fx68k_pkg;

  localparam int PFQ_MAX_DEPTH = 8;

  typedef enum logic [1:0] {
    STOP  = 2'd0,
    RUN   = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } s_pfq_state;

  typedef struct packed {
    logic [15:0] word;
    logic        berr;
  } s_pfq_entry;

endpackage

// File: rtl/fx68k_pfq_ram.sv
// Circular word storage for the prefetch queue: one write port at the tail and a
// two-entry read port (head and head+1), with occupancy tracking.
module fx68k_pfq_ram
  import fx68k_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            en_i,
  input  logic            clr_i,
  input  logic            wr_i,
  input  s_pfq_entry      wdata_i,
  input  logic [1:0]      pop_i,
  output s_pfq_entry      rd0_o,
  output s_pfq_entry      rd1_o,
  output logic [CNTW-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  s_pfq_entry      mem_q [DEPTH];
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [PW-1:0]   rd1_idx;
  logic [CNTW-1:0] cnt_q, cnt_d;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      rd_d  = rd_q + PW'(pop_i);
      if (wr_i) begin
        wr_d = wr_q + PW'(1);
      end
      cnt_d = cnt_q + CNTW'(wr_i) - CNTW'(pop_i);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i && wr_i && !clr_i) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  assign rd1_idx = rd_q + PW'(1);
  assign rd0_o   = mem_q[rd_q];
  assign rd1_o   = mem_q[rd1_idx];
  assign count_o = cnt_q;

endmodule

// File: rtl/fx68k_prefetch_queue.sv
// Instruction prefetch queue: fetches program words ahead of decode into a DEPTH-word FIFO.
// Define FX68K_PFQ_BERR_TAG_EN to defer bus-error reporting until the faulting word reaches the head.
module fx68k_prefetch_queue
  import fx68k_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 24,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            enPhi1,
  input  logic            flush,
  input  logic [AW-1:0]   flushPc,
  output logic            reqValid,
  output logic [AW-1:0]   reqAddr,
  input  logic            reqReady,
  input  logic            rspValid,
  input  logic [15:0]     rspData,
  input  logic            rspBerr,
  output logic            headValid,
  output logic [15:0]     headWord,
  output logic            nextValid,
  output logic [15:0]     nextWord,
  input  logic [1:0]      pop,
  output logic [CNTW-1:0] count,
  output logic            addrErr,
  output logic            fetchBerr
);

  localparam int CW1 = CNTW + 1;

  s_pfq_state      state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            aerr_q, aerr_d;
  logic            berr_q, berr_d;
  logic            wr;
  s_pfq_entry      wdata;
  s_pfq_entry      rd0, rd1;
  logic [CNTW-1:0] cnt;
  logic            unused_ok;

  // A slot is free for a new fetch once this cycle's pop has been applied.
  function automatic logic has_room(input logic [CNTW-1:0] c, input logic [1:0] p);
    logic [CW1-1:0] left;
    left = {1'b0, c} - CW1'(p);
    return left < CW1'(DEPTH);
  endfunction

  // Flush withdraws an unaccepted request so the bus never starts a stale fetch.
  assign reqValid = (state_q == RUN) && !flush && has_room(cnt, pop);
  assign reqAddr  = addr_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    aerr_d  = aerr_q;
    berr_d  = berr_q;
    wr      = 1'b0;
    wdata   = '0;
    if (flush) begin
      addr_d = {flushPc[AW-1:1], 1'b0};
      aerr_d = flushPc[0];
      berr_d = 1'b0;
      if (flushPc[0]) begin
        state_d = STOP;
      end else if (state_q == WAIT || state_q == DRAIN) begin
        state_d = DRAIN;
      end else begin
        state_d = RUN;
      end
    end else begin
      case (state_q)
        RUN: begin
          if (reqValid && reqReady) begin
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (rspValid) begin
            if (rspBerr) begin
              state_d = STOP;
`ifdef FX68K_PFQ_BERR_TAG_EN
              wr         = 1'b1;
              wdata.word = '0;
              wdata.berr = 1'b1;
`else
              berr_d = 1'b1;
`endif
            end else begin
              wr         = 1'b1;
              wdata.word = rspData;
              addr_d     = addr_q + AW'(2);
              state_d    = RUN;
            end
          end
        end
        DRAIN: begin
          if (rspValid) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= STOP;
      addr_q  <= '0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
    end else if (enPhi1) begin
      state_q <= state_d;
      addr_q  <= addr_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
    end
  end

  fx68k_pfq_ram #(
    .DEPTH (DEPTH),
    .CNTW  (CNTW)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .en_i    (enPhi1),
    .clr_i   (flush),
    .wr_i    (wr),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rd0_o   (rd0),
    .rd1_o   (rd1),
    .count_o (cnt)
  );

  // Words are masked while their slot is empty so stale storage never leaks out.
  assign count     = cnt;
  assign headValid = (cnt != '0);
  assign nextValid = (cnt > CNTW'(1));
  assign headWord  = headValid ? rd0.word : 16'h0000;
  assign nextWord  = nextValid ? rd1.word : 16'h0000;
  assign addrErr   = aerr_q;

`ifdef FX68K_PFQ_BERR_TAG_EN
  assign fetchBerr = headValid & rd0.berr;
`else
  assign fetchBerr = berr_q;
`endif

  assign unused_ok = ^{rd0.berr, rd1.berr, berr_q};

  a_pop_legal: assert property (@(posedge clk) disable iff (!resetn)
    (enPhi1 && !flush) |-> (pop != 2'd3 && CNTW'(pop) <= cnt));

endmodule
